// File: rtl/wb_flash_boot_copier_pkg.sv
// Shared types and constants for the flash-to-SSRAM boot copier.
// Provides the FSM state enum and the bus address helper.
package boot_copy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR    = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5,
    ST_ERR   = 3'd6
  } copy_state_e;

  localparam int         FLASH_SEL_BIT = 27;
  localparam logic [3:0] WB_SEL_ALL    = 4'hF;

  // Byte address of 32-bit beat number `beat` above `base`; wraps modulo 2^32.
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [16:0] beat);
    return base + {13'd0, beat, 2'b00};
  endfunction

endpackage

// File: rtl/wb_flash_boot_copier_if.sv
// Wishbone classic bus bundle between the boot copier (master) and the
// shared SSRAM/flash responder (slave).
interface wb_flash_boot_copier_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o,
    output wb_data_i, wb_ack_i
  );
endinterface

// File: rtl/wb_flash_boot_copier_tmo.sv
// Clearable saturating cycle counter used to bound how long a bus
// transaction may wait for its acknowledge.
module wb_tmo_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Count waiting cycles, holding at the last value instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/wb_flash_boot_copier.sv
// Wishbone initiator copying a 16-bit-wide flash image into 32-bit SSRAM:
// two flash reads are packed into one SSRAM write, with a one-cycle idle gap between transactions.
module wb_flash_boot_copier
  import boot_copy_pkg::*;
#(
  parameter int TIMEOUT    = 1024,
  parameter int AUTO_START = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [31:0]                   src_base_i,
  input  logic [31:0]                   dst_base_i,
  input  logic [15:0]                   len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  wb_flash_boot_copier_if.master        wb
);

  copy_state_e state_r;
  copy_state_e last_op_r;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [15:0] len_r;
  logic [15:0] idx_r;
  logic [31:0] buf_r;
  logic        auto_pend_r;

  logic        cyc_r;
  logic        stb_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  sel_r;
  logic [31:0] dat_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  logic        tmo_clr_s;
  logic        tmo_inc_s;
  logic        tmo_expired_s;
  logic        unused_data_s;

  // Flash drives only the low half-word; the upper bits are don't-care.
  assign unused_data_s = ^wb.wb_data_i[31:16];

  assign tmo_clr_s = ~stb_r;
  assign tmo_inc_s = stb_r & ~wb.wb_ack_i;

  wb_tmo_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (tmo_clr_s),
    .inc     (tmo_inc_s),
    .expired (tmo_expired_s)
  );

  // Copy sequencer: owns every bus and status register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      last_op_r   <= ST_IDLE;
      src_r       <= 32'h0;
      dst_r       <= 32'h0;
      len_r       <= 16'h0;
      idx_r       <= 16'h0;
      buf_r       <= 32'h0;
      auto_pend_r <= (AUTO_START != 0);
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0;
      sel_r       <= 4'h0;
      dat_r       <= 32'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          auto_pend_r <= 1'b0;
          if (start_i || auto_pend_r) begin
            src_r  <= src_base_i;
            dst_r  <= dst_base_i;
            len_r  <= len_i;
            idx_r  <= 16'h0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            if (len_i == 16'h0) begin
              state_r <= ST_FIN;
            end else begin
              state_r <= ST_RD_LO;
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              we_r    <= 1'b0;
              sel_r   <= WB_SEL_ALL;
              dat_r   <= 32'h0;
              addr_r  <= src_base_i;
            end
          end
        end

        ST_RD_LO, ST_RD_HI, ST_WR: begin
          if (wb.wb_ack_i) begin
            if (state_r == ST_RD_LO) begin
              buf_r[15:0] <= wb.wb_data_i[15:0];
            end else if (state_r == ST_RD_HI) begin
              buf_r[31:16] <= wb.wb_data_i[15:0];
            end else begin
              idx_r <= idx_r + 16'd1;
            end
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            last_op_r <= state_r;
            state_r   <= ST_GAP;
          end else if (tmo_expired_s) begin
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            state_r <= ST_ERR;
          end
        end

        // Bus is idle for this one cycle; launch whichever transaction follows.
        ST_GAP: begin
          case (last_op_r)
            ST_RD_LO: begin
              state_r <= ST_RD_HI;
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              we_r    <= 1'b0;
              dat_r   <= 32'h0;
              addr_r  <= beat_addr(src_r, {idx_r, 1'b1});
            end
            ST_RD_HI: begin
              state_r <= ST_WR;
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              we_r    <= 1'b1;
              dat_r   <= buf_r;
              addr_r  <= beat_addr(dst_r, {1'b0, idx_r});
            end
            ST_WR: begin
              if (idx_r == len_r) begin
                state_r <= ST_FIN;
              end else begin
                state_r <= ST_RD_LO;
                cyc_r   <= 1'b1;
                stb_r   <= 1'b1;
                we_r    <= 1'b0;
                dat_r   <= 32'h0;
                addr_r  <= beat_addr(src_r, {idx_r, 1'b0});
              end
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end

        ST_FIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end

        ST_ERR: begin
          busy_r  <= 1'b0;
          err_r   <= 1'b1;
          state_r <= ST_IDLE;
        end

        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.wb_cyc_o  = cyc_r;
  assign wb.wb_stb_o  = stb_r;
  assign wb.wb_we_o   = we_r;
  assign wb.wb_addr_o = addr_r;
  assign wb.wb_sel_o  = sel_r;
  assign wb.wb_data_o = dat_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_wb_flash_boot_copier.sv
// Directed bench for wb_flash_boot_copier: latency-programmable responder model
// plus a scoreboard of expected bus transactions.
module tb_wb_flash_boot_copier;
  import boot_copy_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_s = 1'b0;
  logic        start_s = 1'b0;
  logic [31:0] src_s = 32'h0800_0000;
  logic [31:0] dst_s = 32'h0000_0100;
  logic [15:0] len_s = 16'd0;
  logic        busy_s, done_s, err_s;

  logic        t_start_s = 1'b0;
  logic        t_busy_s, t_done_s, t_err_s;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   flash_lat = 1;
  int   sram_lat = 1;
  int   resp_cnt = 0;
  int   cur_lat;
  int   busy_cnt = 0;
  int   done_rises = 0;
  logic done_prev = 1'b0;
  logic cyc_seen = 1'b0;
  logic prev_ack = 1'b0;
  txn_t exp_q[$];

  wb_flash_boot_copier_if bus ();
  wb_flash_boot_copier_if tbus ();

  always #5 clk = ~clk;

  wb_flash_boot_copier dut (
    .clk_i(clk), .rst_i(rst_s), .start_i(start_s),
    .src_base_i(src_s), .dst_base_i(dst_s), .len_i(len_s),
    .busy_o(busy_s), .done_o(done_s), .err_o(err_s),
    .wb(bus)
  );

  wb_flash_boot_copier #(.TIMEOUT(16), .AUTO_START(0)) dut_tmo (
    .clk_i(clk), .rst_i(rst_s), .start_i(t_start_s),
    .src_base_i(32'h0800_0000), .dst_base_i(32'h0000_0000), .len_i(16'd4),
    .busy_o(t_busy_s), .done_o(t_done_s), .err_o(t_err_s),
    .wb(tbus)
  );

  function automatic logic [31:0] flash_rd(input logic [31:0] a);
    if (a == 32'h0800_0000) return 32'h0000_1234;
    else if (a == 32'h0800_0004) return 32'h0000_ABCD;
    else return {~a[15:0], a[15:0] ^ 16'h5AC3};
  endfunction

  // Responder: ack in the Nth cycle of a request, N chosen by flash/SSRAM space.
  assign cur_lat = bus.wb_addr_o[FLASH_SEL_BIT] ? flash_lat : sram_lat;
  assign bus.wb_ack_i = bus.wb_cyc_o && bus.wb_stb_o && (resp_cnt == cur_lat - 1);
  assign bus.wb_data_i = bus.wb_addr_o[FLASH_SEL_BIT] ? flash_rd(bus.wb_addr_o) : 32'hFFFF_FFFF;
  assign tbus.wb_ack_i = 1'b0;
  assign tbus.wb_data_i = 32'h0;

  always @(posedge clk)
    resp_cnt <= (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) ? resp_cnt + 1 : 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic [31:0] src, input logic [31:0] dst, input int len);
    txn_t t;
    logic [31:0] lo, hi;
    for (int w = 0; w < len; w++) begin
      lo = flash_rd(src + 32'(8 * w));
      hi = flash_rd(src + 32'(8 * w + 4));
      t.we = 1'b0; t.addr = src + 32'(8 * w);     t.data = 32'h0; exp_q.push_back(t);
      t.we = 1'b0; t.addr = src + 32'(8 * w + 4); t.data = 32'h0; exp_q.push_back(t);
      t.we = 1'b1; t.addr = dst + 32'(4 * w);     t.data = {hi[15:0], lo[15:0]}; exp_q.push_back(t);
    end
  endtask

  // One cycle of observation, sampled at the falling edge.
  task automatic step();
    txn_t e;
    @(negedge clk);
    if (busy_s) busy_cnt++;
    if (bus.wb_cyc_o) cyc_seen = 1'b1;
    if (done_s && !done_prev) done_rises++;
    done_prev = done_s;
    if (prev_ack) check("gap_idle", {62'b0, bus.wb_cyc_o, bus.wb_stb_o}, 64'd0);
    prev_ack = bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i;
    if (prev_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_txn", {31'b0, bus.wb_we_o, bus.wb_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("txn_we_addr", {31'b0, bus.wb_we_o, bus.wb_addr_o}, {31'b0, e.we, e.addr});
        check("txn_sel", {60'b0, bus.wb_sel_o}, {60'b0, WB_SEL_ALL});
        if (e.we) check("txn_wdata", {32'b0, bus.wb_data_o}, {32'b0, e.data});
      end
    end
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    src_s = src; dst_s = dst; len_s = len;
    push_expect(src, dst, int'(len));
    busy_cnt = 0; done_rises = 0; cyc_seen = 1'b0; done_prev = done_s;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
  endtask

  task automatic run_copy(input int pulse_at);
    int n = 0;
    while (busy_s && n < 2000) begin
      start_s = (n == pulse_at);
      if (n == pulse_at) begin
        src_s = 32'h0800_4000; len_s = 16'd7;
      end
      step();
      n++;
    end
    start_s = 1'b0;
    check("run_budget_busy", {63'b0, busy_s}, 64'd0);
  endtask

  task automatic finish_checks(input int exp_busy);
    check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    check("done_set", {63'b0, done_s}, 64'd1);
    check("err_clear", {63'b0, err_s}, 64'd0);
    check("done_rises", 64'(done_rises), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {58'b0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy_s, done_s, err_s}, 64'd0);
    check("rst_addr", {32'b0, bus.wb_addr_o}, 64'd0);
    check("rst_sel_data", {28'b0, bus.wb_sel_o, bus.wb_data_o}, 64'd0);
  endtask

  initial begin
    int n;
    int stb_cnt;

    // Reset state, then the automatic empty copy on release.
    repeat (3) step();
    check_reset_outputs();
    rst_s = 1'b1;
    busy_cnt = 0; done_rises = 0; cyc_seen = 1'b0; done_prev = 1'b0;
    step();
    check("auto_k1_busy_done", {62'b0, busy_s, done_s}, 64'b10);
    step();
    check("auto_k2_busy_done", {62'b0, busy_s, done_s}, 64'b01);
    check("auto_no_cyc", {63'b0, cyc_seen}, 64'd0);

    // Pack order: 0x1234 then 0xABCD into 0xABCD1234.
    flash_lat = 2; sram_lat = 1;
    start_copy(32'h0800_0000, 32'h0000_0100, 16'd1);
    check("start_k1_busy_stb", {62'b0, busy_s, bus.wb_stb_o}, 64'b11);
    run_copy(-1);
    finish_checks((2 + 1) * 2 + (1 + 1) + 1);

    // Slow flash, three words, ignored start pulse mid-copy.
    flash_lat = 33; sram_lat = 4;
    start_copy(32'h0800_1000, 32'h0000_0200, 16'd3);
    run_copy(40);
    finish_checks(3 * ((33 + 1) * 2 + (4 + 1)) + 1);

    // Empty copy through start_i; clears the earlier done.
    start_copy(32'h0800_0000, 32'h0000_0400, 16'd0);
    check("empty_k1_busy_done", {62'b0, busy_s, done_s}, 64'b10);
    step();
    check("empty_k2_busy_done", {62'b0, busy_s, done_s}, 64'b01);
    check("empty_no_cyc", {63'b0, cyc_seen}, 64'd0);

    // Reset during the second word's high read, then auto restart.
    flash_lat = 3; sram_lat = 2;
    start_copy(32'h0800_2000, 32'h0000_0300, 16'd2);
    n = 0;
    while (!(bus.wb_stb_o && bus.wb_addr_o == 32'h0800_200C) && n < 500) begin
      step();
      n++;
    end
    check("reached_word1_hi", {63'b0, bus.wb_stb_o}, 64'd1);
    rst_s = 1'b0;
    step();
    check_reset_outputs();
    exp_q.delete();
    step();
    push_expect(32'h0800_2000, 32'h0000_0300, 2);
    busy_cnt = 0; done_rises = 0; done_prev = done_s;
    rst_s = 1'b1;
    step();
    check("restart_k1_busy_stb", {62'b0, busy_s, bus.wb_stb_o}, 64'b11);
    run_copy(-1);
    finish_checks(2 * ((3 + 1) * 2 + (2 + 1)) + 1);

    // Timeout instance: responder never acks.
    t_start_s = 1'b1;
    @(negedge clk);
    t_start_s = 1'b0;
    stb_cnt = 0; n = 0;
    while (t_busy_s && n < 200) begin
      if (tbus.wb_stb_o) stb_cnt++;
      @(negedge clk);
      n++;
    end
    check("tmo_stb_cycles", 64'(stb_cnt), 64'd16);
    check("tmo_err_busy_cyc", {61'b0, t_err_s, t_busy_s, tbus.wb_cyc_o}, 64'b100);
    check("tmo_no_done", {63'b0, t_done_s}, 64'd0);
    t_start_s = 1'b1;
    @(negedge clk);
    t_start_s = 1'b0;
    check("tmo_restart_err_busy", {62'b0, t_err_s, t_busy_s}, 64'b01);
    n = 0;
    while (t_busy_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_second_err", {62'b0, t_err_s, t_busy_s}, 64'b10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
